// File: rtl/jtkcpu_simctrl.sv
// jtkcpu_simctrl: simulation-control peripheral for the jtkcpu test environments.
//
// It provides a small register window on the CPU bus. The window contains a finish countdown
// with a pass/fail flag, an echo of the upper address byte (bank), NCH interrupt lines that
// can be raised at once or after a delay, and a bus wait-state generator.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   cen      in   CPU clock enable; gates register writes and delay/wait counters
//   addr     in   24-bit CPU address; addr[15:12]==BASE selects the window, addr[2:0] the register
//   we       in   CPU write strobe
//   din      in   CPU write data
//   dout     out  read data, combinational from addr (0 when not selected)
//   cs       out  window select
//   irq      out  NCH interrupt lines, active high
//   finish   out  one-clk pulse when the finish countdown expires
//   sim_bad  out  fail flag
//   bus_wait out  high while wait states remain for the current access
//
// Register map (addr[2:0]):
//   0 CTRL    W  bit0 start countdown, bit1 sim_bad, bits[7:5] OR-ed into irq when NCH==3
//   1 BANK    R  addr[23:16]
//   2 IRQ_SET W  irq |= din
//   3 IRQ_SEL W  channel select for IRQ_DLY
//   4 IRQ_DLY W  delay for selected channel; non-zero arms it, zero disarms it
//   5 IRQ_ACK W  irq &= ~din
//   6 WAIT    RW wait-state count (0..15)
//   7 STATUS  R  {armed-any, zeros, irq}
module jtkcpu_simctrl #(
  parameter int unsigned NCH        = 3,
  parameter logic [3:0]  BASE       = 4'h1,
  parameter int unsigned FINISH_DLY = 20,
  parameter int unsigned DLYW       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic [23:0]    addr,
  input  logic           we,
  input  logic [7:0]     din,
  output logic [7:0]     dout,
  output logic           cs,
  output logic [NCH-1:0] irq,
  output logic           finish,
  output logic           sim_bad,
  output logic           bus_wait
);

  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegBank   = 3'd1;
  localparam logic [2:0] RegIrqSet = 3'd2;
  localparam logic [2:0] RegIrqSel = 3'd3;
  localparam logic [2:0] RegIrqDly = 3'd4;
  localparam logic [2:0] RegIrqAck = 3'd5;
  localparam logic [2:0] RegWait   = 3'd6;
  localparam logic [2:0] RegStatus = 3'd7;

  localparam logic [7:0] FinLoad = 8'(FINISH_DLY);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       w_cs;
  logic       w_wr;
  logic [2:0] w_idx;
  logic       w_wr_ctrl, w_wr_set, w_wr_sel, w_wr_dly, w_wr_ack, w_wr_wait;

  assign w_cs  = (addr[15:12] == BASE);
  assign w_idx = addr[2:0];
  // A write is taken only on a cen edge, so a strobe held over idle clocks writes once.
  assign w_wr  = w_cs & we & cen;

  assign w_wr_ctrl = w_wr & (w_idx == RegCtrl);
  assign w_wr_set  = w_wr & (w_idx == RegIrqSet);
  assign w_wr_sel  = w_wr & (w_idx == RegIrqSel);
  assign w_wr_dly  = w_wr & (w_idx == RegIrqDly);
  assign w_wr_ack  = w_wr & (w_idx == RegIrqAck);
  assign w_wr_wait = w_wr & (w_idx == RegWait);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]                r_fin_cnt,   w_fin_cnt_nxt;
  logic                      r_finish,    w_finish_nxt;
  logic                      r_sim_bad,   w_sim_bad_nxt;
  logic [NCH-1:0]            r_irq,       w_irq_nxt;
  logic [2:0]                r_sel,       w_sel_nxt;
  logic [NCH-1:0][DLYW-1:0]  r_dly,       w_dly_nxt;
  logic [NCH-1:0]            r_armed,     w_armed_nxt;
  logic [3:0]                r_wait,      w_wait_nxt;
  logic [3:0]                r_wcnt,      w_wcnt_nxt;
  logic [23:0]               r_last_addr, w_last_addr_nxt;

  logic [NCH-1:0]  w_expire;
  logic [NCH-1:0]  w_din_irq;
  logic [NCH-1:0]  w_ctrl_irq;
  logic [DLYW-1:0] w_din_dly;
  logic [7:0]      w_status;

  assign w_din_irq  = din[NCH-1:0];
  assign w_din_dly  = DLYW'(din);
  // Legacy benches raise {nmi,firq,irq} through CTRL[7:5]; only meaningful for three lines.
  assign w_ctrl_irq = (NCH == 3) ? NCH'(din[7:5]) : '0;

  // ---------------------------------------------------------------------------
  // Finish countdown and fail flag (countdown runs on every clk, not on cen)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fin_cnt_nxt = r_fin_cnt;
    w_finish_nxt  = 1'b0;
    w_sim_bad_nxt = r_sim_bad;
    if (w_wr_ctrl) begin
      w_sim_bad_nxt = din[1];
    end
    // A restart wins over an expiry on the same edge, so a restart never adds a pulse.
    if (w_wr_ctrl && din[0]) begin
      w_fin_cnt_nxt = FinLoad;
    end else if (r_fin_cnt == 8'd1) begin
      w_fin_cnt_nxt = 8'd0;
      w_finish_nxt  = 1'b1;
    end else if (r_fin_cnt != 8'd0) begin
      w_fin_cnt_nxt = r_fin_cnt - 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay channels
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_nxt   = r_sel;
    w_dly_nxt   = r_dly;
    w_armed_nxt = r_armed;
    w_expire    = '0;
    if (w_wr_sel) begin
      w_sel_nxt = din[2:0];
    end
    for (int i = 0; i < NCH; i++) begin
      if (cen && r_armed[i]) begin
        if (r_dly[i] == DLYW'(1)) begin
          w_dly_nxt[i]   = '0;
          w_armed_nxt[i] = 1'b0;
          w_expire[i]    = 1'b1;
        end else begin
          w_dly_nxt[i] = r_dly[i] - DLYW'(1);
        end
      end
      // Selects >= NCH match no channel and are dropped.
      if (w_wr_dly && (r_sel == 3'(i))) begin
        w_dly_nxt[i]   = w_din_dly;
        w_armed_nxt[i] = (w_din_dly != '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt lines: set/ack from writes, then delayed expiry last so it wins over an ack
  // ---------------------------------------------------------------------------
  always_comb begin
    w_irq_nxt = r_irq;
    if (w_wr_ctrl) begin
      w_irq_nxt = w_irq_nxt | w_ctrl_irq;
    end
    if (w_wr_set) begin
      w_irq_nxt = w_irq_nxt | w_din_irq;
    end
    if (w_wr_ack) begin
      w_irq_nxt = w_irq_nxt & ~w_din_irq;
    end
    w_irq_nxt = w_irq_nxt | w_expire;
  end

  // ---------------------------------------------------------------------------
  // Wait-state generator: any change of bus address on a cen edge is a new access
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wait_nxt      = r_wait;
    w_wcnt_nxt      = r_wcnt;
    w_last_addr_nxt = r_last_addr;
    if (w_wr_wait) begin
      w_wait_nxt = din[3:0];
    end
    if (cen) begin
      if (addr != r_last_addr) begin
        w_last_addr_nxt = addr;
        // Uses the count in force before this edge; a WAIT write applies to the next access.
        w_wcnt_nxt      = r_wait;
      end else if (r_wcnt != 4'd0) begin
        w_wcnt_nxt = r_wcnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fin_cnt   <= '0;
      r_finish    <= 1'b0;
      r_sim_bad   <= 1'b0;
      r_irq       <= '0;
      r_sel       <= '0;
      r_dly       <= '0;
      r_armed     <= '0;
      r_wait      <= '0;
      r_wcnt      <= '0;
      r_last_addr <= '0;
    end else begin
      r_fin_cnt   <= w_fin_cnt_nxt;
      r_finish    <= w_finish_nxt;
      r_sim_bad   <= w_sim_bad_nxt;
      r_irq       <= w_irq_nxt;
      r_sel       <= w_sel_nxt;
      r_dly       <= w_dly_nxt;
      r_armed     <= w_armed_nxt;
      r_wait      <= w_wait_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_last_addr <= w_last_addr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    w_status    = '0;
    w_status[7] = |r_armed;
    // With NCH==8 the irq bits overwrite armed-any: the upper bit is truncated.
    for (int i = 0; i < NCH; i++) begin
      w_status[i] = r_irq[i];
    end
  end

  always_comb begin
    dout = '0;
    if (w_cs) begin
      case (w_idx)
        RegBank:   dout = addr[23:16];
        RegWait:   dout = {4'b0000, r_wait};
        RegStatus: dout = w_status;
        default:   dout = '0;
      endcase
    end
  end

  assign cs       = w_cs;
  assign irq      = r_irq;
  assign finish   = r_finish;
  assign sim_bad  = r_sim_bad;
  assign bus_wait = (r_wcnt != 4'd0);

endmodule
